key_schedule_seq: RTL and testbench

//  Sequential AES key-schedule engine. Runtime-selectable 128/192/256-bit key; produces
//  one 32-bit schedule word per cycle through a single 4-byte S-box path. Emits Nr+1
//  128-bit round keys in order over a valid/ready stream to the round datapath.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox_word.sv | 12 +
 rtl/key_schedule_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_key_schedule_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length and FSM enums, Rcon table, S-box table,
// and helpers mapping a key length to Nk (words) and Nr (rounds).
package aes_pkg;

  typedef enum logic [1:0] {KL128 = 2'd0, KL192 = 2'd1, KL256 = 2'd2} key_len_e;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} ks_state_e;

  localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL128:   return 4'd4;
      KL192:   return 4'd6;
      KL256:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL128:   return 4'd10;
      KL192:   return 4'd12;
      KL256:   return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel S-box byte lookups on a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {sub_byte(din[31:24]), sub_byte(din[23:16]),
                 sub_byte(din[15:8]),  sub_byte(din[7:0])};

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES key schedule: one 32-bit schedule word per cycle through a
// single SubWord path, round keys streamed over a valid/ready interface.
// Optional macro KS_INVERSE_EN adds the inv port and a round-key store so the
// schedule can be replayed in reverse order (Nr..0) for decryption.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = MAX_NK + 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [MAX_NK*32-1:0] key,
  output logic                busy,
  output logic                err,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_idx,
  output logic                rk_last
`ifdef KS_INVERSE_EN
  ,input logic                inv
`endif
);

  ks_state_e        state_q, state_d;
  logic [3:0]       nk_q, nk_d, nr_q, nr_d, rcon_q, rcon_d;
  logic [5:0]       i_q, i_d;
  logic [2:0]       pos_q, pos_d;
  logic [7:0][31:0] win_q, win_d;
  logic             err_q, err_d, rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
  logic [127:0]     rk_data_q, rk_data_d;
  logic [3:0]       rk_idx_q, rk_idx_d;

  logic [3:0]       nk_new, nr_new;
  logic             legal, hs, gen, inv_mode;
  logic [2:0]       nk_m1;
  logic [5:0]       i_last;
  logic [31:0]      prev_w, old_w, sbox_in, sbox_out, w_new;
  logic [127:0]     grp_w;

`ifdef KS_INVERSE_EN
  logic             inv_q, inv_d, more_q, more_d, st_we;
  logic [3:0]       rd_q, rd_d, st_addr;
  logic [127:0]     st_wdata;
  logic [127:0]     store_q [MAX_NR+1];
  assign inv_mode = inv_q;
`else
  assign inv_mode = 1'b0;
`endif

  assign nk_new  = nk_of(key_len_e'(key_len));
  assign nr_new  = nr_of(key_len_e'(key_len));
  assign legal   = (key_len != 2'd3) && (int'(nk_new) <= MAX_NK);
  assign nk_m1   = 3'(nk_q - 4'd1);
  assign i_last  = {nr_q, 2'b11};
  assign hs      = rk_valid_q && rk_ready;
  // Any un-taken round key freezes the whole word pipeline.
  assign gen     = (state_q == S_RUN) && (i_q <= i_last) && !(rk_valid_q && !rk_ready);
  assign prev_w  = win_q[0];
  assign old_w   = win_q[nk_m1];
  assign sbox_in = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign grp_w   = {win_q[2], win_q[1], win_q[0], w_new};

  aes_sbox_word u_sbox (.din(sbox_in), .dout(sbox_out));

  // Next schedule word. For i<Nk the window was preloaded so that the oldest
  // slot already holds key word i.
  always_comb begin
    w_new = old_w ^ prev_w;
    if ({2'b00, nk_q} > i_q)
      w_new = old_w;
    else if (pos_q == 3'd0)
      w_new = old_w ^ sbox_out ^ {RCON[rcon_q], 24'h0};
    else if (nk_q == 4'd8 && pos_q == 3'd4)
      w_new = old_w ^ sbox_out;
  end

  // FSM next state, counters, window and output register.
  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    i_d        = i_q;
    pos_d      = pos_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    err_d      = 1'b0;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
`ifdef KS_INVERSE_EN
    inv_d    = inv_q;
    more_d   = more_q;
    rd_d     = rd_q;
    st_we    = 1'b0;
    st_addr  = i_q[5:2];
    st_wdata = grp_w;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            state_d = S_RUN;
            nk_d    = nk_new;
            nr_d    = nr_new;
            i_d     = 6'd0;
            pos_d   = 3'd0;
            rcon_d  = 4'd1;
            win_d   = '0;
            // Key word 0 goes to slot Nk-1 so it is the first "oldest" word.
            for (int j = 0; j < 8; j++)
              for (int k = 0; k < MAX_NK; k++)
                if (int'(nk_new) == j + k + 1)
                  win_d[j] = key[(MAX_NK-k)*32-1 -: 32];
`ifdef KS_INVERSE_EN
            inv_d = inv;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          rk_valid_d = 1'b0;
          if (rk_last_q) state_d = S_IDLE;
        end
        if (gen) begin
          win_d  = {win_q[6:0], w_new};
          i_d    = i_q + 6'd1;
          pos_d  = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
          if (pos_q == 3'd0 && i_q >= {2'b00, nk_q}) rcon_d = rcon_q + 4'd1;
          if (i_q[1:0] == 2'b11 && !inv_mode) begin
            rk_valid_d = 1'b1;
            rk_data_d  = grp_w;
            rk_idx_d   = i_q[5:2];
            rk_last_d  = (i_q[5:2] == nr_q);
          end
`ifdef KS_INVERSE_EN
          if (i_q[1:0] == 2'b11 && inv_mode) st_we = 1'b1;
          if (inv_mode && i_q == i_last) begin
            state_d = S_DRAIN;
            rd_d    = nr_q;
            more_d  = 1'b1;
          end
`endif
        end
      end
`ifdef KS_INVERSE_EN
      S_DRAIN: begin
        if (hs) begin
          rk_valid_d = 1'b0;
          if (rk_last_q) state_d = S_IDLE;
        end
        if ((!rk_valid_q || rk_ready) && more_q) begin
          rk_valid_d = 1'b1;
          rk_data_d  = store_q[rd_q];
          rk_idx_d   = rd_q;
          rk_last_d  = (rd_q == 4'd0);
          if (rd_q == 4'd0) more_d = 1'b0;
          else              rd_d   = rd_q - 4'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nk_q       <= '0;
      nr_q       <= '0;
      i_q        <= '0;
      pos_q      <= '0;
      rcon_q     <= '0;
      win_q      <= '0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
`ifdef KS_INVERSE_EN
      inv_q      <= 1'b0;
      more_q     <= 1'b0;
      rd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      pos_q      <= pos_d;
      rcon_q     <= rcon_d;
      win_q      <= win_d;
      err_q      <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
`ifdef KS_INVERSE_EN
      inv_q      <= inv_d;
      more_q     <= more_d;
      rd_q       <= rd_d;
`endif
    end
  end

`ifdef KS_INVERSE_EN
  // Round-key store for reverse replay; contents need no reset.
  always_ff @(posedge clk) begin
    if (st_we) store_q[st_addr] <= st_wdata;
  end
`endif

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq using FIPS-197 key-expansion vectors.
module tb_key_schedule_seq;

  localparam logic [127:0] RK0      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK128_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] RK128_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] RK192_1  = 128'h10111213141516175846f2f95c43f4fe;
  localparam logic [127:0] RK192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] RK256_1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         rk_ready = 1'b1;
  logic         busy, err, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
`ifdef KS_INVERSE_EN
  logic         inv = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [127:0] g_data [16];
  logic [3:0]   g_idx  [16];
  logic         g_last [16];
  int           g_cyc  [16];
  int           nkeys, stab_bad, busy_fall, ord_bad;

  key_schedule_seq #(.MAX_NK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
`ifdef KS_INVERSE_EN
    , .inv(inv)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (E0); key/key_len are scrambled right after.
  task automatic start_sched(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    key     = ~k;
    key_len = 2'd1;
  endtask

  // Observe the stream; c is the index of the negedge following edge Ec.
  task automatic collect(input int limit, input bit rand_ready);
    logic [127:0] hold_d;
    logic [3:0]   hold_i;
    bit           have_hold;
    have_hold = 1'b0;
    hold_d    = '0;
    hold_i    = '0;
    nkeys     = 0;
    stab_bad  = 0;
    busy_fall = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
      if (have_hold) begin
        if (!rk_valid || rk_data !== hold_d || rk_idx !== hold_i) stab_bad++;
        have_hold = 1'b0;
      end
      if (rk_valid && rk_ready) begin
        if (nkeys < 16) begin
          g_data[nkeys] = rk_data;
          g_idx[nkeys]  = rk_idx;
          g_last[nkeys] = rk_last;
          g_cyc[nkeys]  = c;
        end
        nkeys++;
      end else if (rk_valid) begin
        have_hold = 1'b1;
        hold_d    = rk_data;
        hold_i    = rk_idx;
      end
      if (!busy && busy_fall < 0) busy_fall = c;
      if (busy_fall >= 0 && c >= busy_fall + 3) break;
    end
    rk_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  128'(busy), 128'd0);
    chk("rst_err",   128'(err), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_last",  128'(rk_last), 128'd0);
    chk("rst_data",  rk_data, 128'd0);
    chk("rst_idx",   128'(rk_idx), 128'd0);
    rst_n = 1'b1;

    // AES-128
    start_sched(2'd0, K128);
    collect(80, 1'b0);
    chk("a128_count", 128'(nkeys), 128'd11);
    chk("a128_rk0",   g_data[0], RK0);
    chk("a128_idx0",  128'(g_idx[0]), 128'd0);
    chk("a128_cyc0",  128'(g_cyc[0]), 128'd4);
    chk("a128_rk1",   g_data[1], RK128_1);
    chk("a128_rk10",  g_data[10], RK128_10);
    chk("a128_idx10", 128'(g_idx[10]), 128'd10);
    chk("a128_last10", 128'(g_last[10]), 128'd1);
    chk("a128_last9", 128'(g_last[9]), 128'd0);
    chk("a128_cyc10", 128'(g_cyc[10]), 128'd44);
    chk("a128_busyfall", 128'(busy_fall), 128'd45);

    // AES-192
    start_sched(2'd1, K192);
    collect(90, 1'b0);
    chk("a192_count", 128'(nkeys), 128'd13);
    chk("a192_rk1",   g_data[1], RK192_1);
    chk("a192_rk12",  g_data[12], RK192_12);
    chk("a192_last12", 128'(g_last[12]), 128'd1);
    chk("a192_busyfall", 128'(busy_fall), 128'd53);

    // AES-256
    start_sched(2'd2, K256);
    collect(100, 1'b0);
    chk("a256_count", 128'(nkeys), 128'd15);
    chk("a256_rk0",   g_data[0], RK0);
    chk("a256_rk1",   g_data[1], RK256_1);
    chk("a256_rk14",  g_data[14], RK256_14);
    chk("a256_idx14", 128'(g_idx[14]), 128'd14);
    chk("a256_busyfall", 128'(busy_fall), 128'd61);

    // AES-128 under random backpressure
    start_sched(2'd0, K128);
    collect(600, 1'b1);
    chk("bp_count", 128'(nkeys), 128'd11);
    chk("bp_stable", 128'(stab_bad), 128'd0);
    ord_bad = 0;
    for (int k = 0; k < 11; k++)
      if (g_idx[k] !== 4'(k)) ord_bad++;
    chk("bp_order", 128'(ord_bad), 128'd0);
    chk("bp_rk1",  g_data[1], RK128_1);
    chk("bp_rk10", g_data[10], RK128_10);
    chk("bp_last10", 128'(g_last[10]), 128'd1);

    // Illegal key length
    @(negedge clk);
    key_len = 2'd3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    @(negedge clk);
    chk("ill_err",   128'(err), 128'd1);
    chk("ill_busy",  128'(busy), 128'd0);
    chk("ill_valid", 128'(rk_valid), 128'd0);
    @(negedge clk);
    chk("ill_err_pulse", 128'(err), 128'd0);
    chk("ill_busy2", 128'(busy), 128'd0);

    // Start while busy is ignored
    start_sched(2'd0, K128);
    repeat (3) @(negedge clk);
    key_len = 2'd2;
    key     = K256;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    collect(80, 1'b0);
    chk("sbusy_count", 128'(nkeys), 128'd11);
    chk("sbusy_rk0",   g_data[0], RK0);
    chk("sbusy_rk10",  g_data[10], RK128_10);

    // Asynchronous reset while round key 5 is presented
    start_sched(2'd0, K128);
    repeat (25) @(negedge clk);
    chk("mid_valid_before", 128'(rk_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 128'(rk_valid), 128'd0);
    chk("mid_busy",  128'(busy), 128'd0);
    chk("mid_data",  rk_data, 128'd0);
    chk("mid_idx",   128'(rk_idx), 128'd0);
    chk("mid_last",  128'(rk_last), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_sched(2'd2, K256);
    collect(100, 1'b0);
    chk("post_count", 128'(nkeys), 128'd15);
    chk("post_rk0",   g_data[0], RK0);
    chk("post_rk14",  g_data[14], RK256_14);

`ifdef KS_INVERSE_EN
    // Reverse replay of an AES-256 schedule
    inv = 1'b1;
    start_sched(2'd2, K256);
    inv = 1'b0;
    collect(140, 1'b0);
    chk("inv_count", 128'(nkeys), 128'd15);
    chk("inv_first", g_data[0], RK256_14);
    chk("inv_idx0",  128'(g_idx[0]), 128'd14);
    chk("inv_cyc0",  128'(g_cyc[0]), 128'd61);
    chk("inv_last0", 128'(g_last[0]), 128'd0);
    chk("inv_rk1",   g_data[13], RK256_1);
    chk("inv_final", g_data[14], RK0);
    chk("inv_idxf",  128'(g_idx[14]), 128'd0);
    chk("inv_lastf", 128'(g_last[14]), 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
